// File: rtl/riscv_pkg.sv
// Shared constants for the multi-cycle RISC-V core: opcodes, FSM states,
// ALU op codes and datapath mux selects.
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } mc_state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_ALUOUT = 1'b1;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MDR    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RISC-V core: sequences fetch, decode,
// execute, memory and writeback over a shared ALU and unified memory port.
module multicycle_controller
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       illegal,
    output logic [3:0] state
);

    mc_state_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    assign state = state_q;

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = ADR_PC;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        result_src = RES_ALUOUT;
        illegal    = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                alu_op     = ALUOP_ADD;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                // Opcode is re-sampled here; anything but lw/sw traps.
                if (opcode == OP_LW)      state_d = S_MEMREAD;
                else if (opcode == OP_SW) state_d = S_MEMWRITE;
                else                      state_d = S_TRAP;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = ADR_ALUOUT;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_MDR;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = ADR_ALUOUT;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_RTYPE;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_op     = ALUOP_SUB;
                result_src = RES_ALUOUT;
                pc_write   = zero;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALUOUT;
                pc_write   = 1'b1;
                state_d    = S_ALUWB;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: state_d = S_TRAP;
        endcase

        // While reset is held, present the FETCH decode with mem_ready masked
        // so no strobe from an interrupted state leaks out.
        if (reset) begin
            mem_req    = 1'b1;
            mem_write  = 1'b0;
            adr_src    = ADR_PC;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = SRCA_PC;
            alu_src_b  = SRCB_FOUR;
            alu_op     = ALUOP_ADD;
            result_src = RES_ALU;
            illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction expected
// state/output traces built from the instruction-level behaviour.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset, zero, mem_ready;
    logic [6:0] opcode;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic [3:0] state;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IA = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

    int tests = 0;
    int fails = 0;
    int q_st[$];
    bit q_mr[$];

    logic [14:0] act;
    assign act = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                  alu_src_a, alu_src_b, alu_op, result_src, illegal};

    // Expected output vector for a state, straight from the per-state table.
    function automatic logic [14:0] exp_out(int st, bit mr, bit z);
        logic mq = 0, mw = 0, as = 0, irw = 0, pcw = 0, rw = 0, il = 0;
        logic [1:0] a = 0, b = 0, op = 0, res = 0;
        case (st)
            0:  begin mq = 1; b = 2'b10; res = 2'b10; irw = mr; pcw = mr; end
            1:  begin a = 2'b01; b = 2'b01; end
            2:  begin a = 2'b10; b = 2'b01; end
            3:  begin mq = 1; as = 1; end
            4:  begin res = 2'b01; rw = 1; end
            5:  begin mq = 1; mw = 1; as = 1; end
            6:  begin a = 2'b10; b = 2'b00; op = 2'b10; end
            7:  begin a = 2'b10; b = 2'b01; end
            8:  begin rw = 1; end
            9:  begin a = 2'b10; op = 2'b01; pcw = z; end
            10: begin a = 2'b01; b = 2'b10; pcw = 1; end
            11: begin il = 1; end
            default: ;
        endcase
        return {mq, mw, as, irw, pcw, rw, a, b, op, res, il};
    endfunction

    function automatic void push(int s, bit m);
        q_st.push_back(s);
        q_mr.push_back(m);
    endfunction

    // Build the expected state trace of one instruction from its cycle budget.
    function automatic void build(logic [6:0] op, int fs, int ms);
        q_st.delete();
        q_mr.delete();
        repeat (fs) push(0, 0);
        push(0, 1);
        push(1, 1'($urandom));
        case (op)
            LW: begin
                push(2, 1'($urandom));
                repeat (ms) push(3, 0);
                push(3, 1);
                push(4, 1'($urandom));
            end
            SW: begin
                push(2, 1'($urandom));
                repeat (ms) push(5, 0);
                push(5, 1);
            end
            RT: begin push(6, 1'($urandom)); push(8, 1'($urandom)); end
            IA: begin push(7, 1'($urandom)); push(8, 1'($urandom)); end
            BQ: push(9, 1'($urandom));
            JL: begin push(10, 1'($urandom)); push(8, 1'($urandom)); end
            default: repeat (10) push(11, 1'($urandom));
        endcase
    endfunction

    task automatic run_queue(input string name, input logic [6:0] op, input bit z);
        for (int i = 0; i < q_st.size(); i++) begin
            @(negedge clk);
            mem_ready = q_mr[i];
            opcode    = (q_st[i] == 1 || q_st[i] == 2) ? op : 7'($urandom);
            zero      = (q_st[i] == 9) ? z : 1'($urandom);
            #1;
            tests++;
            if (state !== 4'(q_st[i])) begin
                fails++;
                $display("FAIL %s cyc%0d state got %0d expected %0d", name, i, state, q_st[i]);
            end
            tests++;
            if (act !== exp_out(q_st[i], mem_ready, zero)) begin
                fails++;
                $display("FAIL %s cyc%0d outputs got %h expected %h (state %0d)",
                         name, i, act, exp_out(q_st[i], mem_ready, zero), q_st[i]);
            end
        end
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        tests++;
        if (state !== 4'd0 || act !== exp_out(0, 0, 0)) begin
            fails++;
            $display("FAIL %s idle state got %0d outputs %h expected state 0 outputs %h",
                     name, state, act, exp_out(0, 0, 0));
        end
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        reset     = 1'b1;
        mem_ready = 1'b1;
        opcode    = 7'($urandom);
        zero      = 1'($urandom);
        #1;
        tests++;
        if (act !== exp_out(0, 0, 0)) begin
            fails++;
            $display("FAIL %s during reset outputs got %h expected %h", name, act, exp_out(0, 0, 0));
        end
        @(negedge clk);
        reset     = 1'b0;
        mem_ready = 1'b0;
        #1;
        tests++;
        if (state !== 4'd0 || act !== exp_out(0, 0, 0)) begin
            fails++;
            $display("FAIL %s after reset state got %0d outputs %h expected 0 / %h",
                     name, state, act, exp_out(0, 0, 0));
        end
    endtask

    task automatic test_reset();
        do_reset("reset");
    endtask

    task automatic test_lw();
        build(LW, 0, 0);
        run_queue("lw", LW, 0);
        check_idle("lw");
    endtask

    task automatic test_sw_stall();
        build(SW, 0, 2);
        run_queue("sw_stall", SW, 0);
        check_idle("sw_stall");
    endtask

    task automatic test_beq();
        build(BQ, 0, 0);
        run_queue("beq_taken", BQ, 1);
        build(BQ, 0, 0);
        run_queue("beq_not", BQ, 0);
        check_idle("beq");
    endtask

    task automatic test_rtype_jal();
        build(RT, 1, 0);
        run_queue("rtype", RT, 0);
        build(JL, 0, 0);
        run_queue("jal", JL, 0);
        build(IA, 0, 0);
        run_queue("iadd", IA, 0);
        check_idle("rtype_jal");
    endtask

    task automatic test_trap();
        build(7'b1111111, 0, 0);
        for (int i = 2; i < q_mr.size(); i++) q_mr[i] = bit'(i % 2);
        run_queue("trap", 7'b1111111, 0);
        do_reset("trap_reset");
    endtask

    task automatic test_reset_midstall();
        build(LW, 0, 5);
        q_st = q_st[0:4];
        q_mr = q_mr[0:4];
        run_queue("midstall", LW, 0);
        do_reset("midstall_reset");
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops[6] = '{LW, SW, RT, IA, BQ, JL};
        logic [6:0] op;
        for (int n = 0; n < 40; n++) begin
            op = ops[$urandom_range(0, 5)];
            build(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
            run_queue("random", op, 1'($urandom));
        end
        check_idle("random");
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b0;
        opcode    = '0;
        zero      = 1'b0;
        test_reset();
        test_lw();
        test_sw_stall();
        test_beq();
        test_rtype_jal();
        test_trap();
        test_reset_midstall();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
